// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed common-anode 7-seg scanner
// with double-buffered frames committed at frame boundaries.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int TICK_DIV    = 1000,
  parameter int BLANK_TICKS = 1,
  parameter int SHOW_TICKS  = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [3:0]              nibble_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   digit_an,
  output logic                    frame_done,
  output logic                    pending
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MT = (BLANK_TICKS > SHOW_TICKS) ?
                      BLANK_TICKS : SHOW_TICKS;
  localparam int TW = $clog2(MT + 1);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t                  state, state_n;
  logic [IW-1:0]           idx, idx_n;
  logic [PW-1:0]           presc, presc_n;
  logic [TW-1:0]           tcnt, tcnt_n;
  logic [3:0]              nib_n;
  logic                    dp_n;
  logic [NUM_DIGITS-1:0]   an_n;
  logic                    fd_n;
  logic [4*NUM_DIGITS-1:0] act_data, pend_data;
  logic [NUM_DIGITS-1:0]   act_dp, pend_dp;
  logic                    tick, last, commit;
  logic [NUM_DIGITS-1:0]   an_sel;

  always_comb begin
    tick   = (state != IDLE) &&
             (presc == PW'(TICK_DIV - 1));
    last   = (idx == IW'(NUM_DIGITS - 1));
    an_sel = ~(NUM_DIGITS'(1) << idx);
    commit = frame_done || (state == IDLE);
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    presc_n = tick ? '0 : presc + PW'(1);
    tcnt_n  = tcnt;
    nib_n   = nibble_out;
    dp_n    = dp_out;
    an_n    = '1;
    fd_n    = 1'b0;
    unique case (state)
      IDLE: begin
        presc_n = '0;
        idx_n   = '0;
        tcnt_n  = '0;
        if (enable) state_n = BLANK;
      end
      BLANK: begin
        if (tick) begin
          if (tcnt == TW'(BLANK_TICKS - 1)) begin
            state_n = SHOW;
            tcnt_n  = '0;
            an_n    = an_sel;
            nib_n   = act_data[{idx, 2'b00} +: 4];
            dp_n    = ~act_dp[idx];
          end else begin
            tcnt_n = tcnt + TW'(1);
          end
        end
      end
      SHOW: begin
        an_n = an_sel;
        if (tick) begin
          if (tcnt == TW'(SHOW_TICKS - 1)) begin
            state_n = BLANK;
            tcnt_n  = '0;
            an_n    = '1;
            idx_n   = last ? '0 : idx + IW'(1);
            fd_n    = last;
          end else begin
            tcnt_n = tcnt + TW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // dropping enable mid-scan aborts the frame silently
    if (!enable && state != IDLE) begin
      state_n = IDLE;
      idx_n   = '0;
      tcnt_n  = '0;
      presc_n = '0;
      an_n    = '1;
      fd_n    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      presc      <= '0;
      tcnt       <= '0;
      nibble_out <= '0;
      dp_out     <= 1'b1;
      digit_an   <= '1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      presc      <= presc_n;
      tcnt       <= tcnt_n;
      nibble_out <= nib_n;
      dp_out     <= dp_n;
      digit_an   <= an_n;
      frame_done <= fd_n;
    end
  end

  // commit window is the frame_done cycle or any idle cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      act_data  <= '0;
      act_dp    <= '0;
      pend_data <= '0;
      pend_dp   <= '0;
      pending   <= 1'b0;
    end else if (load && commit) begin
      act_data <= data_in;
      act_dp   <= dp_in;
      pending  <= 1'b0;
    end else if (load) begin
      pend_data <= data_in;
      pend_dp   <= dp_in;
      pending   <= 1'b1;
    end else if (commit && pending) begin
      act_data <= pend_data;
      act_dp   <= pend_dp;
      pending  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl
// with TICK_DIV=4, BLANK_TICKS=1, SHOW_TICKS=3, 4 digits.
module tb_seg_scan_ctrl;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         load;
  logic [15:0]  data_in;
  logic [3:0]   dp_in;
  logic [3:0]   nibble_out;
  logic         dp_out;
  logic [3:0]   digit_an;
  logic         frame_done;
  logic         pending;

  int checks = 0;
  int errors = 0;
  int mchecks = 0;
  int merrors = 0;
  int cyc = 0;

  logic [8:0] exp_q[$];
  logic [8:0] e;
  logic [3:0] prev_an = 4'hF;
  logic       en_q = 1'b0;
  logic       tracking = 1'b0;
  int         len = 0;

  seg_scan_ctrl #(
    .NUM_DIGITS (N),
    .TICK_DIV   (4),
    .BLANK_TICKS(1),
    .SHOW_TICKS (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .load      (load),
    .data_in   (data_in),
    .dp_in     (dp_in),
    .nibble_out(nibble_out),
    .dp_out    (dp_out),
    .digit_an  (digit_an),
    .frame_done(frame_done),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    en_q <= enable;
  end

  // scoreboard monitor: pops one entry per lit digit slot
  always @(negedge clk) begin
    if (!rst) begin
      mchecks++;
      if ($countones(~digit_an) > 1) begin
        merrors++;
        $display("FAIL one_cold: an=%b", digit_an);
      end
      if (digit_an !== 4'hF && prev_an === 4'hF) begin
        len = 0;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          tracking = 1'b1;
          mchecks++;
          if ({digit_an, nibble_out, dp_out} !== e) begin
            merrors++;
            $display("FAIL scoreboard: got an=%b nib=%h dp=%b want an=%b nib=%h dp=%b",
                     digit_an, nibble_out, dp_out,
                     e[8:5], e[4:1], e[0]);
          end
        end
      end
      if (digit_an !== 4'hF) begin
        len++;
      end else if (prev_an !== 4'hF && tracking) begin
        tracking = 1'b0;
        if (en_q) begin
          mchecks++;
          if (len != 12) begin
            merrors++;
            $display("FAIL show_len: got %0d want 12", len);
          end
        end
      end
    end
    prev_an = digit_an;
  end

  task automatic push_frame(input logic [15:0] d,
                            input logic [3:0] dp);
    for (int k = 0; k < N; k++) begin
      logic [3:0] an;
      an = ~(4'b0001 << k);
      exp_q.push_back({an, d[4*k +: 4], ~dp[k]});
    end
  endtask

  task automatic wait_fd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_an(input logic [3:0] v, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (digit_an === v) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_load(input logic [15:0] d,
                            input logic [3:0] dp);
    load = 1'b1;
    data_in = d;
    dp_in = dp;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_reset;
    bit ok;
    int bad;
    rst = 1'b1;
    enable = 1'b0;
    load = 1'b1;
    data_in = 16'hFFFF;
    dp_in = 4'hF;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    load = 1'b0;
    data_in = '0;
    dp_in = '0;
    checks++;
    if (digit_an !== 4'hF) begin
      errors++;
      $display("FAIL rst_an: got %b want 1111", digit_an);
    end
    checks++;
    if (nibble_out !== 4'h0) begin
      errors++;
      $display("FAIL rst_nib: got %h want 0", nibble_out);
    end
    checks++;
    if (dp_out !== 1'b1) begin
      errors++;
      $display("FAIL rst_dp: got %b want 1", dp_out);
    end
    checks++;
    if (pending !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_flags: got pend=%b fd=%b want 0 0",
               pending, frame_done);
    end
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (digit_an !== 4'hF) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_dark: got %0d lit cycles want 0", bad);
    end
    // load during reset must not have reached the active frame
    push_frame(16'h0000, 4'h0);
    enable = 1'b1;
    wait_fd(ok);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rst_frame: got ok=%0d left=%0d want 1 0",
               ok, exp_q.size());
    end
    enable = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_scan_order;
    bit ok;
    int c0, t1, t2, dark;
    pulse_load(16'h4321, 4'b0100);
    checks++;
    if (pending !== 1'b0) begin
      errors++;
      $display("FAIL idle_load_pend: got %b want 0", pending);
    end
    push_frame(16'h4321, 4'b0100);
    enable = 1'b1;
    c0 = cyc;
    dark = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (digit_an === 4'hF) dark++;
      else break;
    end
    checks++;
    if (dark != 4) begin
      errors++;
      $display("FAIL first_blank: got %0d want 4", dark);
    end
    wait_fd(ok);
    t1 = cyc;
    checks++;
    if (!ok || t1 - c0 != 65) begin
      errors++;
      $display("FAIL first_fd: got ok=%0d at %0d want 65",
               ok, t1 - c0);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scan_left: got %0d want 0", exp_q.size());
    end
    wait_fd(ok);
    t2 = cyc;
    checks++;
    if (!ok || t2 - t1 != 64) begin
      errors++;
      $display("FAIL fd_period: got %0d want 64", t2 - t1);
    end
  endtask

  task automatic test_tear_free;
    bit ok;
    push_frame(16'h4321, 4'b0100);
    push_frame(16'hABCD, 4'b0001);
    wait_an(4'b1101, ok);
    repeat (5) @(negedge clk);
    pulse_load(16'hABCD, 4'b0001);
    checks++;
    if (!ok || pending !== 1'b1) begin
      errors++;
      $display("FAIL tear_pend: got ok=%0d pend=%b want 1 1",
               ok, pending);
    end
    wait_fd(ok);
    @(negedge clk);
    checks++;
    if (!ok || pending !== 1'b0) begin
      errors++;
      $display("FAIL tear_commit: got ok=%0d pend=%b want 1 0",
               ok, pending);
    end
    wait_fd(ok);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      errors++;
      $display("FAIL tear_left: got ok=%0d left=%0d want 1 0",
               ok, exp_q.size());
    end
  endtask

  task automatic test_load_commit;
    bit ok;
    @(negedge clk);
    push_frame(16'hABCD, 4'b0001);
    push_frame(16'h5555, 4'b1000);
    pulse_load(16'h9999, 4'hF);
    checks++;
    if (pending !== 1'b1) begin
      errors++;
      $display("FAIL lc_pend: got %b want 1", pending);
    end
    wait_fd(ok);
    pulse_load(16'h5555, 4'b1000);
    checks++;
    if (!ok || pending !== 1'b0) begin
      errors++;
      $display("FAIL lc_commit: got ok=%0d pend=%b want 1 0",
               ok, pending);
    end
    wait_fd(ok);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      errors++;
      $display("FAIL lc_left: got ok=%0d left=%0d want 1 0",
               ok, exp_q.size());
    end
  endtask

  task automatic test_enable_drop;
    bit ok;
    int fd_seen, dark;
    wait_an(4'b1011, ok);
    repeat (3) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if (!ok || digit_an !== 4'hF) begin
      errors++;
      $display("FAIL drop_an: got ok=%0d an=%b want 1 1111",
               ok, digit_an);
    end
    fd_seen = (frame_done === 1'b0) ? 0 : 1;
    repeat (10) begin
      @(negedge clk);
      if (frame_done !== 1'b0) fd_seen++;
    end
    checks++;
    if (fd_seen != 0) begin
      errors++;
      $display("FAIL drop_fd: got %0d pulses want 0", fd_seen);
    end
    push_frame(16'h5555, 4'b1000);
    enable = 1'b1;
    dark = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (digit_an === 4'hF) dark++;
      else break;
    end
    checks++;
    if (dark != 4) begin
      errors++;
      $display("FAIL restart_blank: got %0d want 4", dark);
    end
    wait_fd(ok);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      errors++;
      $display("FAIL restart_left: got ok=%0d left=%0d want 1 0",
               ok, exp_q.size());
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    @(negedge clk);
    push_frame(16'h5555, 4'b1000);
    push_frame(16'h2222, 4'b0010);
    pulse_load(16'h1111, 4'b1111);
    repeat (10) @(negedge clk);
    pulse_load(16'h2222, 4'b0010);
    checks++;
    if (pending !== 1'b1) begin
      errors++;
      $display("FAIL b2b_pend: got %b want 1", pending);
    end
    wait_fd(ok);
    wait_fd(ok);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_left: got ok=%0d left=%0d want 1 0",
               ok, exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    load = 1'b0;
    data_in = '0;
    dp_in = '0;
    test_reset();
    test_scan_order();
    test_tear_free();
    test_load_commit();
    test_enable_drop();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks + mchecks, errors + merrors);
    $finish;
  end

endmodule
